scale_controller: RTL and testbench
===================================

SCALE_CONTROLLER -- requirements
Module: scale_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 371250: cycles the synchronized button level must be stable before it is accepted (~5 ms at 74.25 MHz).
REQ-002 SHALL have parameter SRC_W, default 240: frame-buffer width in pixels.
REQ-003 SHALL have parameter SRC_H, default 320: frame-buffer height in pixels.
REQ-004 SHALL have port clk_pixel_in, input, 1 bit: the only clock.
REQ-005 SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_in, input, 1 bit: raw, unsynchronized scale-cycle button.
REQ-007 SHALL have port hcount_in, input, 11 bits: display column; increments by 1 per cycle within a line.
REQ-008 SHALL have port vcount_in, input, 10 bits: display row.
REQ-009 SHALL have port new_frame_in, input, 1 bit: one-cycle pulse during vertical blanking.
REQ-010 SHALL have port scale_out, output, 2 bits: active scale mode (0 = 1x, 1 = 2x, 2 = 8/3x); drives the camera window selector.
REQ-011 SHALL have port pending_out, output, 1 bit: a mode change is queued and not yet applied.
REQ-012 SHALL have port addr_out, output, 17 bits: frame-buffer read address, row*SRC_W + col.
REQ-013 SHALL have port addr_valid_out, output, 1 bit: addr_out lies inside the active window.

Function
REQ-014 SHALL pass btn_in through a 2-flop synchronizer, then a debounce counter that clears on any level change and accepts the new level when the count reaches DEBOUNCE_CYCLES-1.
REQ-015 SHALL detect a rising edge of the debounced level and produce one press event per edge.
REQ-016 SHALL, on each press event, advance the pending mode 0->1->2->0 from the current pending mode and set pending_out=1; mode 3 SHALL never be produced.
REQ-017 SHALL copy the pending mode into scale_out on the edge after new_frame_in and clear pending_out in the same edge; scale_out SHALL NOT change at any other time.
REQ-018 SHALL, when a press event and new_frame_in coincide, apply the pre-press pending mode, advance pending by one and leave pending_out=1.
REQ-019 SHALL, for multiple presses within one frame, apply only the final pending mode at the next new_frame_in.
REQ-020 SHALL define the window from registered scale_out as: mode 0 h<240, v<320; mode 1 h<480, v<640; mode 2 h<640, v<853.
REQ-021 SHALL map source column and row as: mode 0 col=h, row=v; mode 1 col=h>>1, row=v>>1; mode 2 col=floor(3h/8), row=floor(3v/8).
REQ-022 SHALL implement mode 2 with a 3-bit DDA per axis: add 3 per step; on a carry past 7, subtract 8 and increment col or row. No multipliers or dividers SHALL be used.
REQ-023 SHALL maintain a row-base register that adds SRC_W on each row increment, so that addr = row_base + col.
REQ-024 SHALL reset the column state (col and accumulator) when hcount_in==0.
REQ-025 SHALL advance the row state when hcount_in==0 and vcount_in!=0, and reset it when hcount_in==0 and vcount_in==0.
REQ-026 SHALL register addr_out and addr_valid_out with exactly 1 cycle of latency from hcount_in and vcount_in.
REQ-027 SHALL drive addr_out=0 and addr_valid_out=0 outside the window.
REQ-028 SHALL keep addr_out <= SRC_W*SRC_H-1 (76799) in every mode; col SHALL NOT exceed 239 and row SHALL NOT exceed 319.

Reset
REQ-029 SHALL, while rst_n_in=0, force asynchronously: scale_out=0, pending mode=0, pending_out=0, addr_out=0, addr_valid_out=0, synchronizer flops=0, debounced level=0, debounce counter=0, and all col/row/accumulator/row-base state=0.
REQ-030 SHALL, on reset assertion mid-press or mid-frame, discard any queued change; after release, SHALL require a full new debounce period before accepting a press.

Verification
REQ-031 SHALL cover: btn high for DEBOUNCE_CYCLES+2 cycles, then new_frame_in -> pending_out=1 after the debounce, then scale_out=1 and pending_out=0 one cycle after the pulse.
REQ-032 SHALL cover: btn glitch of 100 cycles -> no press event; scale_out and pending_out unchanged.
REQ-033 SHALL cover: three presses in one frame from mode 0 -> scale_out=0 at the next frame (0->1->2->0); a fourth press -> scale_out=1.
REQ-034 SHALL cover: mode 1, h=479, v=639 -> next cycle addr_out=319*240+239=76799, valid=1; h=480 -> addr_out=0, valid=0.
REQ-035 SHALL cover: mode 2, h=8, v=8 -> addr_out=3*240+3=723; h=639, v=852 -> addr_out=76799; v=853 -> valid=0.
REQ-036 SHALL cover: press event coincident with new_frame_in while pending mode=1 -> scale_out=1, pending mode=2, pending_out=1.

Source files
------------

// File: rtl/scale_controller.sv
// Scale-mode controller: debounced button cycles a queued 1x/2x/8-3x mode that is
// applied at frame boundaries, and a DDA-based frame-buffer address generator.
module scale_controller #(
   parameter int DEBOUNCE_CYCLES = 371250,
   parameter int SRC_W           = 240,
   parameter int SRC_H           = 320
) (
   input  logic        clk_pixel_in,
   input  logic        rst_n_in,
   input  logic        btn_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        new_frame_in,
   output logic [1:0]  scale_out,
   output logic        pending_out,
   output logic [16:0] addr_out,
   output logic        addr_valid_out
);

   typedef enum logic [1:0] {
      MODE_1X   = 2'd0,
      MODE_2X   = 2'd1,
      MODE_8_3X = 2'd2
   } mode_t;

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [10:0] WIN_W_1X  = 11'(SRC_W);
   localparam logic [10:0] WIN_W_2X  = 11'(2 * SRC_W);
   localparam logic [10:0] WIN_W_83X = 11'((8 * SRC_W) / 3);
   localparam logic [9:0]  WIN_H_1X  = 10'(SRC_H);
   localparam logic [9:0]  WIN_H_2X  = 10'(2 * SRC_H);
   localparam logic [9:0]  WIN_H_83X = 10'((8 * SRC_H) / 3);

   localparam logic [10:0] COL_LIM  = 11'(SRC_W);
   localparam logic [9:0]  ROW_LIM  = 10'(SRC_H);
   localparam logic [16:0] ROW_STEP = 17'(SRC_W);

   // ------------------------------------------------------------------
   // Button synchronizer and debounce
   // ------------------------------------------------------------------
   logic [1:0]       sync_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             db_reg;
   logic             db_prev_reg;
   logic             press;

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync_reg    <= 2'b00;
         cnt_reg     <= '0;
         db_reg      <= 1'b0;
         db_prev_reg <= 1'b0;
      end else begin
         sync_reg    <= {sync_reg[0], btn_in};
         db_prev_reg <= db_reg;
         // Any return to the accepted level restarts the stability count
         if (sync_reg[1] == db_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            db_reg  <= sync_reg[1];
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign press = db_reg & ~db_prev_reg;

   // ------------------------------------------------------------------
   // Pending / active mode
   // ------------------------------------------------------------------
   mode_t pend_reg;
   mode_t pend_next;
   mode_t scale_reg;
   mode_t scale_next;
   logic  pending_reg;
   logic  pending_next;

   function automatic mode_t advance_mode(input mode_t m);
      case (m)
         MODE_1X: advance_mode = MODE_2X;
         MODE_2X: advance_mode = MODE_8_3X;
         default: advance_mode = MODE_1X;
      endcase
   endfunction

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pend_reg    <= MODE_1X;
         scale_reg   <= MODE_1X;
         pending_reg <= 1'b0;
      end else begin
         pend_reg    <= pend_next;
         scale_reg   <= scale_next;
         pending_reg <= pending_next;
      end
   end

   // A press coinciding with the frame pulse is queued behind the mode being applied
   always_comb begin
      pend_next    = pend_reg;
      scale_next   = scale_reg;
      pending_next = pending_reg;
      if (new_frame_in) begin
         scale_next   = pend_reg;
         pending_next = 1'b0;
      end
      if (press) begin
         pend_next    = advance_mode(pend_reg);
         pending_next = 1'b1;
      end
   end

   assign scale_out   = scale_reg;
   assign pending_out = pending_reg;

   // ------------------------------------------------------------------
   // Address generation
   // ------------------------------------------------------------------
   logic [10:0] col_reg;
   logic [2:0]  col_acc_reg;
   logic [9:0]  row_reg;
   logic [2:0]  row_acc_reg;
   logic [16:0] row_base_reg;

   logic [3:0]  step_inc;
   logic [10:0] win_w;
   logic [9:0]  win_h;
   logic [3:0]  col_sum;
   logic [3:0]  row_sum;
   logic [10:0] col_cur;
   logic [2:0]  col_acc_cur;
   logic [9:0]  row_cur;
   logic [2:0]  row_acc_cur;
   logic [16:0] row_base_cur;
   logic        in_window;
   logic [16:0] addr_next;

   // Accumulator step per pixel: 8 always carries (1x), 4 carries every
   // other pixel (2x), 3 gives floor(3n/8) (8/3x)
   always_comb begin
      step_inc = 4'd8;
      win_w    = WIN_W_1X;
      win_h    = WIN_H_1X;
      case (scale_reg)
         MODE_2X: begin
            step_inc = 4'd4;
            win_w    = WIN_W_2X;
            win_h    = WIN_H_2X;
         end
         MODE_8_3X: begin
            step_inc = 4'd3;
            win_w    = WIN_W_83X;
            win_h    = WIN_H_83X;
         end
         default: begin
            step_inc = 4'd8;
            win_w    = WIN_W_1X;
            win_h    = WIN_H_1X;
         end
      endcase
   end

   always_comb begin
      col_sum = {1'b0, col_acc_reg} + step_inc;
      row_sum = {1'b0, row_acc_reg} + step_inc;

      col_cur     = col_reg + 11'(col_sum[3]);
      col_acc_cur = col_sum[2:0];
      if (hcount_in == 11'd0) begin
         col_cur     = 11'd0;
         col_acc_cur = 3'd0;
      end

      row_cur      = row_reg;
      row_acc_cur  = row_acc_reg;
      row_base_cur = row_base_reg;
      if (hcount_in == 11'd0) begin
         if (vcount_in == 10'd0) begin
            row_cur      = 10'd0;
            row_acc_cur  = 3'd0;
            row_base_cur = 17'd0;
         end else begin
            row_cur      = row_reg + 10'(row_sum[3]);
            row_acc_cur  = row_sum[2:0];
            row_base_cur = row_sum[3] ? (row_base_reg + ROW_STEP) : row_base_reg;
         end
      end

      // Source bounds guard keeps the address inside the frame buffer
      in_window = (hcount_in < win_w) && (vcount_in < win_h) &&
                  (col_cur < COL_LIM) && (row_cur < ROW_LIM);
      addr_next = in_window ? (row_base_cur + {6'd0, col_cur}) : 17'd0;
   end

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         col_reg        <= 11'd0;
         col_acc_reg    <= 3'd0;
         row_reg        <= 10'd0;
         row_acc_reg    <= 3'd0;
         row_base_reg   <= 17'd0;
         addr_out       <= 17'd0;
         addr_valid_out <= 1'b0;
      end else begin
         col_reg        <= col_cur;
         col_acc_reg    <= col_acc_cur;
         row_reg        <= row_cur;
         row_acc_reg    <= row_acc_cur;
         row_base_reg   <= row_base_cur;
         addr_out       <= addr_next;
         addr_valid_out <= in_window;
      end
   end

endmodule

// File: tb/tb_scale_controller.sv
// Bench for scale_controller: mode sequencing via button/frame model, address
// corner vectors and randomized scans checked against arithmetic mapping.
module tb_scale_controller;

   localparam int D     = 128;
   localparam int SRC_W = 240;
   localparam int SRC_H = 320;

   logic        clk_pixel_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        btn_in = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [9:0]  vcount_in = '0;
   logic        new_frame_in = 1'b0;
   logic [1:0]  scale_out;
   logic        pending_out;
   logic [16:0] addr_out;
   logic        addr_valid_out;

   scale_controller #(
      .DEBOUNCE_CYCLES(D),
      .SRC_W(SRC_W),
      .SRC_H(SRC_H)
   ) dut (
      .clk_pixel_in(clk_pixel_in),
      .rst_n_in(rst_n_in),
      .btn_in(btn_in),
      .hcount_in(hcount_in),
      .vcount_in(vcount_in),
      .new_frame_in(new_frame_in),
      .scale_out(scale_out),
      .pending_out(pending_out),
      .addr_out(addr_out),
      .addr_valid_out(addr_valid_out)
   );

   always #5 clk_pixel_in = ~clk_pixel_in;

   typedef struct {
      string name;
      int    mode;
      int    v;
      int    h;
      int    exp_addr;
      int    exp_valid;
   } vec_t;

   vec_t vecs[12];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_pend  = 0;
   int   m_scale = 0;
   int   m_flag  = 0;
   int   lat     = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_state(input string p);
      check({p, "_scale"}, int'(scale_out), m_scale);
      check({p, "_pending"}, int'(pending_out), m_flag);
   endtask

   // Expected address from the mapping rules: window, then col/row scaling
   function automatic void ref_addr(input int mode, input int x, input int y,
                                    output int a, output int val);
      int ww, wh, col, row;
      case (mode)
         1:       begin ww = 2 * SRC_W;       wh = 2 * SRC_H;       col = x / 2;       row = y / 2;       end
         2:       begin ww = (8 * SRC_W) / 3; wh = (8 * SRC_H) / 3; col = (3 * x) / 8; row = (3 * y) / 8; end
         default: begin ww = SRC_W;           wh = SRC_H;           col = x;           row = y;           end
      endcase
      val = (x < ww && y < wh) ? 1 : 0;
      a   = val ? row * SRC_W + col : 0;
   endfunction

   task automatic drive_check(input int x, input int y);
      int ea, ev;
      @(negedge clk_pixel_in);
      hcount_in = 11'(x);
      vcount_in = 10'(y);
      @(posedge clk_pixel_in);
      #1;
      ref_addr(m_scale, x, y, ea, ev);
      if (int'(addr_out) != ea || int'(addr_valid_out) != ev)
         check($sformatf("scan m%0d h%0d v%0d addr/valid", m_scale, x, y),
               int'(addr_out) * 2 + int'(addr_valid_out), ea * 2 + ev);
      else
         n_tests++;
   endtask

   task automatic scan_to(input int ty, input int tx);
      for (int y = 0; y <= ty; y++) begin
         int hm;
         hm = (y == ty) ? tx : 0;
         for (int x = 0; x <= hm; x++) drive_check(x, y);
      end
   endtask

   task automatic park();
      @(negedge clk_pixel_in);
      hcount_in = '0;
      vcount_in = '0;
   endtask

   // Button press; optionally pulse new_frame on the cycle the press lands
   task automatic btn_seq(input bit with_frame);
      for (int i = 1; i <= 2 * D + 12; i++) begin
         @(negedge clk_pixel_in);
         btn_in       = (i <= D + 2);
         new_frame_in = with_frame && (i == lat);
         @(posedge clk_pixel_in);
      end
      @(negedge clk_pixel_in);
      btn_in       = 1'b0;
      new_frame_in = 1'b0;
      if (with_frame) m_scale = m_pend;
      m_pend = (m_pend + 1) % 3;
      m_flag = 1;
      check_state(with_frame ? "press_with_frame" : "press");
   endtask

   task automatic frame();
      @(negedge clk_pixel_in);
      new_frame_in = 1'b1;
      @(posedge clk_pixel_in);
      #1;
      m_scale = m_pend;
      m_flag  = 0;
      check_state("frame");
      @(negedge clk_pixel_in);
      new_frame_in = 1'b0;
   endtask

   task automatic set_mode(input int t);
      while (m_pend != t) btn_seq(1'b0);
      if (m_scale != t || m_flag != 0) frame();
   endtask

   initial begin
      vecs[0]  = '{"m1_last_pixel",   1, 639, 479, 76799, 1};
      vecs[1]  = '{"m1_h480_out",     1, 639, 480, 0,     0};
      vecs[2]  = '{"m1_origin",       1, 0,   0,   0,     1};
      vecs[3]  = '{"m1_h5_v3",        1, 3,   5,   242,   1};
      vecs[4]  = '{"m2_h8_v8",        2, 8,   8,   723,   1};
      vecs[5]  = '{"m2_last_pixel",   2, 852, 639, 76799, 1};
      vecs[6]  = '{"m2_v853_out",     2, 853, 0,   0,     0};
      vecs[7]  = '{"m2_h640_out",     2, 852, 640, 0,     0};
      vecs[8]  = '{"m0_last_pixel",   0, 319, 239, 76799, 1};
      vecs[9]  = '{"m0_v320_out",     0, 320, 0,   0,     0};
      vecs[10] = '{"m0_h240_out",     0, 0,   240, 0,     0};
      vecs[11] = '{"m0_h7_v10",       0, 10,  7,   2407,  1};

      // Reset state
      repeat (3) @(posedge clk_pixel_in);
      #1;
      check("reset_scale", int'(scale_out), 0);
      check("reset_pending", int'(pending_out), 0);
      check("reset_addr", int'(addr_out), 0);
      check("reset_valid", int'(addr_valid_out), 0);
      @(negedge clk_pixel_in);
      rst_n_in = 1'b1;

      // First press: measure when pending_out rises
      lat = 0;
      for (int i = 1; i <= 2 * D + 12; i++) begin
         @(negedge clk_pixel_in);
         btn_in = (i <= D + 2);
         @(posedge clk_pixel_in);
         #1;
         if (pending_out && lat == 0) lat = i;
      end
      @(negedge clk_pixel_in);
      btn_in = 1'b0;
      m_pend = 1;
      m_flag = 1;
      check("press_latency_in_range", int'(lat >= D + 2 && lat <= D + 6), 1);
      if (lat == 0) lat = D + 3;
      check_state("first_press");
      frame();
      check("first_frame_scale_is_1", int'(scale_out), 1);

      // 100-cycle glitch must not register
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_pixel_in);
         btn_in = 1'b1;
      end
      @(negedge clk_pixel_in);
      btn_in = 1'b0;
      repeat (D + 10) @(posedge clk_pixel_in);
      #1;
      check_state("glitch");

      // Three presses in one frame from mode 0, then a fourth
      set_mode(0);
      for (int i = 0; i < 3; i++) btn_seq(1'b0);
      frame();
      check("three_press_scale_is_0", int'(scale_out), 0);
      btn_seq(1'b0);
      frame();
      check("fourth_press_scale_is_1", int'(scale_out), 1);

      // Press lands on the frame pulse while pending mode is 1
      btn_seq(1'b1);
      check("coincident_scale_is_1", int'(scale_out), 1);
      check("coincident_pending_is_1", int'(pending_out), 1);
      frame();
      check("coincident_queued_mode_2", int'(scale_out), 2);

      // Address corner vectors
      for (int k = 0; k < 12; k++) begin
         set_mode(vecs[k].mode);
         scan_to(vecs[k].v, vecs[k].h);
         check({vecs[k].name, "_addr"}, int'(addr_out), vecs[k].exp_addr);
         check({vecs[k].name, "_valid"}, int'(addr_valid_out), vecs[k].exp_valid);
         park();
      end

      // Reset in the middle of a press discards the queue
      btn_seq(1'b0);
      @(negedge clk_pixel_in);
      btn_in = 1'b1;
      repeat (D / 2) @(posedge clk_pixel_in);
      #2;
      rst_n_in = 1'b0;
      #1;
      m_pend  = 0;
      m_scale = 0;
      m_flag  = 0;
      check_state("async_reset");
      check("async_reset_addr", int'(addr_out), 0);
      check("async_reset_valid", int'(addr_valid_out), 0);
      @(negedge clk_pixel_in);
      rst_n_in = 1'b1;
      repeat (D / 2) @(posedge clk_pixel_in);
      #1;
      check_state("post_reset_no_early_press");
      repeat (D) @(posedge clk_pixel_in);
      #1;
      m_pend = 1;
      m_flag = 1;
      check_state("post_reset_full_debounce");
      @(negedge clk_pixel_in);
      btn_in = 1'b0;
      repeat (D + 8) @(posedge clk_pixel_in);
      frame();

      // Randomized operations and scans
      for (int it = 0; it < 8; it++) begin
         int op, wv, ww, ty, tx;
         op = int'($urandom_range(0, 2));
         if (op == 0) btn_seq(1'b0);
         else if (op == 1) frame();
         else btn_seq(1'b1);
         wv = (m_scale == 0) ? SRC_H : (m_scale == 1) ? 2 * SRC_H : (8 * SRC_H) / 3;
         ww = (m_scale == 0) ? SRC_W : (m_scale == 1) ? 2 * SRC_W : (8 * SRC_W) / 3;
         ty = int'($urandom_range(0, wv + 1));
         tx = int'($urandom_range(0, ww + 1));
         scan_to(ty, tx);
         park();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
